// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - control FSM sequencing a multicycle MIPS datapath
// Per-state control words, memory ready handshake and stalled-access timeout abort.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       mem_err,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // A zero timeout disables the abort; WAIT_LAST is then never consulted.
  localparam logic       TIMEOUT_EN = 1'(MEM_TIMEOUT != 0);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_state;
  logic       timeout;
  logic       opcode_legal;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
  assign timeout   = TIMEOUT_EN && mem_state && !mem_ready && (wait_cnt_q == WAIT_LAST);
  assign opcode_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                        (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  assign state = state_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        case (opcode)
          OP_LW:   state_d = S_MEM_READ;
          OP_SW:   state_d = S_MEM_WRITE;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_EXECUTE:  state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    // A FETCH timeout stays in FETCH, so it must clear the counter explicitly.
    if ((state_d != state_q) || timeout)
      wait_cnt_d = 8'd0;
    else if (mem_state && !mem_ready && (wait_cnt_q != 8'hFF))
      wait_cnt_d = wait_cnt_q + 8'd1;
    else
      wait_cnt_d = wait_cnt_q;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = timeout && RESET;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready && RESET;
        IRWrite = mem_ready && RESET;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !opcode_legal;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready && RESET;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
// Instruction-path reference model plus directed literal checks and random traffic.
module tb_multicycle_control;

  localparam int TO = 4;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ILL  = 6'b111111;

  logic       CLK, RESET, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, mem_err, illegal_op;
  logic [15:0] dut_word;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done), .mem_err(mem_err),
    .illegal_op(illegal_op)
  );

  assign dut_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Static control word per state, bit order matching dut_word.
  logic [15:0] word_tab [0:15];
  initial begin
    for (int i = 0; i < 16; i++) word_tab[i] = 16'h0000;
    word_tab[0]  = 16'h1010;
    word_tab[1]  = 16'h0030;
    word_tab[2]  = 16'h0060;
    word_tab[3]  = 16'h3000;
    word_tab[4]  = 16'h0280;
    word_tab[5]  = 16'h2800;
    word_tab[6]  = 16'h0048;
    word_tab[7]  = 16'h0180;
    word_tab[8]  = 16'h4045;
    word_tab[9]  = 16'h8002;
    word_tab[10] = 16'h0060;
    word_tab[11] = 16'h0080;
  end

  // Model: current step plus the remaining steps of the decoded instruction.
  int m_st = 0, m_wait = 0, m_next = 0, m_wnext = 0;
  int m_path[$];

  function automatic int take_next();
    if (m_path.size() > 0) return m_path.pop_front();
    return 0;
  endfunction

  always @(negedge CLK) begin
    logic rdy, to, legal, is_mem;
    logic [15:0] ew;
    if (!RESET) begin
      m_st = 0; m_wait = 0; m_path.delete();
    end
    rdy    = mem_ready;
    is_mem = (m_st == 0) || (m_st == 3) || (m_st == 5);
    legal  = opcode inside {LW, SW, RT, BEQ, JMP, ADDI};
    to     = (TO != 0) && is_mem && !rdy && (m_wait == TO - 1);
    ew     = word_tab[m_st];
    if (RESET && m_st == 0 && rdy) ew = ew | 16'h8400;
    chk("state", {28'd0, state}, m_st);
    chk("ctrl_word", {16'd0, dut_word}, {16'd0, ew});
    chk("instr_done", {31'd0, instr_done},
        {31'd0, RESET && ((m_st inside {4, 7, 8, 9, 11}) || (m_st == 5 && rdy))});
    chk("mem_err", {31'd0, mem_err}, {31'd0, RESET && to});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, RESET && m_st == 1 && !legal});

    m_wnext = 0;
    if (is_mem && !rdy) begin
      if (to) begin
        m_next = 0; m_path.delete();
      end else begin
        m_next  = m_st;
        m_wnext = (m_wait < 255) ? m_wait + 1 : 255;
      end
    end else if (m_st == 0) begin
      m_next = 1;
    end else if (m_st == 1) begin
      case (opcode)
        LW:      m_path = '{2, 3, 4};
        SW:      m_path = '{2, 5};
        RT:      m_path = '{6, 7};
        BEQ:     m_path = '{8};
        JMP:     m_path = '{9};
        ADDI:    m_path = '{10, 11};
        default: m_path.delete();
      endcase
      m_next = take_next();
    end else begin
      m_next = take_next();
    end
  end

  always @(posedge CLK) begin
    if (!RESET) begin
      m_st = 0; m_wait = 0; m_path.delete();
    end else begin
      m_st = m_next; m_wait = m_wnext;
    end
  end

  task automatic drive(input logic [5:0] op, input logic rdy);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    opcode = op;
    mem_ready = rdy;
    @(negedge CLK);
    #1;
  endtask

  int lw_trace [6] = '{0, 1, 2, 3, 4, 0};
  int burst, rst_left;

  initial begin
    RESET = 1'b1; mem_ready = 1'b1; opcode = LW;
    #1 RESET = 1'b0;
    @(negedge CLK); #1;
    chk("rst_state", {28'd0, state}, 0);
    chk("rst_memread", {31'd0, MemRead}, 1);
    chk("rst_pcwrite", {31'd0, PCWrite}, 0);
    chk("rst_irwrite", {31'd0, IRWrite}, 0);
    chk("rst_alusrcb", {30'd0, ALUSrcB}, 1);

    for (int i = 0; i < 6; i++) begin
      drive(LW, 1'b1);
      chk("lw_state", {28'd0, state}, lw_trace[i]);
      chk("lw_regwrite", {31'd0, RegWrite}, (i == 4) ? 1 : 0);
      chk("lw_memtoreg", {31'd0, MemtoReg}, (i == 4) ? 1 : 0);
      chk("lw_done", {31'd0, instr_done}, (i == 4) ? 1 : 0);
    end
    drive(RT, 1'b1); chk("r_dec", {28'd0, state}, 1);
    drive(RT, 1'b1); chk("r_exe", {28'd0, state}, 6);
    drive(RT, 1'b1); chk("r_wb", {28'd0, state}, 7);
    chk("r_regdst", {31'd0, RegDst}, 1);

    for (int i = 0; i < 4; i++) begin
      drive(ADDI, (i == 3));
      chk("stall_state", {28'd0, state}, 0);
      chk("stall_irwrite", {31'd0, IRWrite}, (i == 3) ? 1 : 0);
      chk("stall_pcwrite", {31'd0, PCWrite}, (i == 3) ? 1 : 0);
    end
    drive(ADDI, 1'b1); chk("addi_dec", {28'd0, state}, 1);
    drive(ADDI, 1'b1); chk("addi_ex", {28'd0, state}, 10);
    drive(ADDI, 1'b1); chk("addi_wb", {28'd0, state}, 11);
    chk("addi_regwrite", {31'd0, RegWrite}, 1);
    chk("addi_regdst", {31'd0, RegDst}, 0);

    drive(SW, 1'b1); chk("sw_fetch", {28'd0, state}, 0);
    drive(SW, 1'b1);
    drive(SW, 1'b1); chk("sw_addr", {28'd0, state}, 2);
    for (int i = 0; i < 4; i++) begin
      drive(SW, 1'b0);
      chk("to_state", {28'd0, state}, 5);
      chk("to_memwrite", {31'd0, MemWrite}, 1);
      chk("to_memerr", {31'd0, mem_err}, (i == 3) ? 1 : 0);
      chk("to_done", {31'd0, instr_done}, 0);
    end
    drive(ILL, 1'b0); chk("to_after", {28'd0, state}, 0);

    drive(ILL, 1'b1);
    drive(ILL, 1'b1);
    chk("ill_state", {28'd0, state}, 1);
    chk("ill_flag", {31'd0, illegal_op}, 1);
    chk("ill_regwrite", {31'd0, RegWrite}, 0);
    drive(ILL, 1'b0);
    chk("ill_after", {28'd0, state}, 0);
    chk("ill_clear", {31'd0, illegal_op}, 0);

    drive(BEQ, 1'b1); drive(BEQ, 1'b1);
    drive(BEQ, 1'b1); chk("beq_state", {28'd0, state}, 8);
    chk("beq_word", {16'd0, dut_word}, 32'h4045);
    drive(JMP, 1'b1); chk("beq_len", {28'd0, state}, 0);
    drive(JMP, 1'b1);
    drive(JMP, 1'b1); chk("j_state", {28'd0, state}, 9);
    chk("j_word", {16'd0, dut_word}, 32'h8002);
    drive(SW, 1'b0); chk("j_len", {28'd0, state}, 0);

    drive(SW, 1'b1); drive(SW, 1'b1); drive(SW, 1'b1);
    drive(SW, 1'b0); chk("mid_pre", {28'd0, state}, 5);
    RESET = 1'b0; mem_ready = 1'b1;
    #1;
    chk("mid_state", {28'd0, state}, 0);
    chk("mid_memwrite", {31'd0, MemWrite}, 0);
    chk("mid_pcwrite", {31'd0, PCWrite}, 0);
    repeat (3) @(posedge CLK);
    drive(RT, 1'b1);
    chk("rel_state", {28'd0, state}, 0);
    chk("rel_word", {16'd0, dut_word}, 32'h9410);

    burst = 0; rst_left = 0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge CLK);
      #1;
      if (rst_left > 0) begin
        rst_left--;
        RESET = (rst_left == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b0;
        rst_left = $urandom_range(1, 2);
      end
      if (m_st == 0) begin
        case ($urandom_range(0, 7))
          0: opcode = LW;
          1: opcode = SW;
          2: opcode = RT;
          3: opcode = BEQ;
          4: opcode = JMP;
          5: opcode = ADDI;
          default: opcode = 6'($urandom);
        endcase
      end
      if (burst > 0) begin
        burst--;
        mem_ready = 1'b0;
      end else if ($urandom_range(0, 11) == 0) begin
        burst = $urandom_range(1, 7);
        mem_ready = 1'b0;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
